// File: rtl/i2s_clk_ctrl.sv
// rtl/i2s_clk_ctrl.sv - I2S master bclk/wclk sequencer with frame counter and rx watchdog
module i2s_clk_ctrl #(
  parameter int SLOT_BITS = 16,
  parameter int DIV_W     = 8,
  parameter int TIMEOUT   = 4096
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  input  logic             rx_data_valid,
  output logic             bclk,
  output logic             wclk,
  output logic             running,
  output logic [15:0]      frame_count,
  output logic             rx_timeout
);

  localparam int BIT_W = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(SLOT_BITS - 1);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    TAIL  = 2'd3
  } state_t;

  state_t           state_q;
  logic [DIV_W-1:0] div_l_q;
  logic [DIV_W-1:0] hcnt_q;
  logic [BIT_W-1:0] bitcnt_q;
  logic [WD_W-1:0]  wdcnt_q;
  logic [WD_W-1:0]  wdcnt_d;
  logic             bclk_q;
  logic             wclk_q;
  logic             running_q;
  logic             rx_timeout_q;
  logic [15:0]      frame_count_q;

  // Edge qualifiers derived from the current counter state.
  logic half_done;
  logic period_done;
  logic slot_done;
  logic frame_done;

  assign half_done   = (hcnt_q == div_l_q);
  assign period_done = half_done & bclk_q;                   // bclk about to fall
  assign slot_done   = period_done & (bitcnt_q == LAST_BIT);
  assign frame_done  = slot_done & wclk_q;                   // wclk about to fall
  assign wdcnt_d     = wdcnt_q + WD_W'(1);

  assign bclk        = bclk_q;
  assign wclk        = wclk_q;
  assign running     = running_q;
  assign frame_count = frame_count_q;
  assign rx_timeout  = rx_timeout_q;

  // Bus sequencer: divider, bit/slot counters, start/drain/tail control.
  always_ff @(posedge mclk) begin
    if (reset) begin
      state_q       <= IDLE;
      div_l_q       <= '0;
      hcnt_q        <= '0;
      bitcnt_q      <= '0;
      bclk_q        <= 1'b0;
      wclk_q        <= 1'b0;
      running_q     <= 1'b0;
      frame_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          hcnt_q   <= '0;
          bitcnt_q <= '0;
          bclk_q   <= 1'b0;
          wclk_q   <= 1'b0;
          if (enable) begin
            state_q   <= RUN;
            running_q <= 1'b1;
            div_l_q   <= div;
          end
        end
        RUN, DRAIN: begin
          if (half_done) begin
            hcnt_q <= '0;
            bclk_q <= ~bclk_q;
          end else begin
            hcnt_q <= hcnt_q + DIV_W'(1);
          end
          if (period_done) begin
            bitcnt_q <= slot_done ? '0 : bitcnt_q + BIT_W'(1);
          end
          if (slot_done) begin
            wclk_q <= ~wclk_q;
          end
          if (frame_done) begin
            frame_count_q <= frame_count_q + 16'd1;
          end
          // A stop request only changes state; timing keeps running untouched.
          if (state_q == RUN && !enable) begin
            state_q <= DRAIN;
          end
          if (state_q == DRAIN && frame_done) begin
            state_q <= TAIL;
          end
        end
        TAIL: begin
          // One extra bclk period with wclk low, ending on the would-be falling edge.
          if (half_done) begin
            hcnt_q <= '0;
            if (bclk_q) begin
              bclk_q    <= 1'b0;
              state_q   <= IDLE;
              running_q <= 1'b0;
            end else begin
              bclk_q <= 1'b1;
            end
          end else begin
            hcnt_q <= hcnt_q + DIV_W'(1);
          end
        end
        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
          bclk_q    <= 1'b0;
          wclk_q    <= 1'b0;
        end
      endcase
    end
  end

  // Watchdog on rx_data_valid: saturating count while the bus is clocking data.
  always_ff @(posedge mclk) begin
    if (reset) begin
      wdcnt_q      <= '0;
      rx_timeout_q <= 1'b0;
    end else if (state_q == IDLE) begin
      wdcnt_q <= '0;
      if (enable) begin
        rx_timeout_q <= 1'b0;
      end
    end else if (rx_data_valid) begin
      wdcnt_q <= '0;
    end else if (state_q != TAIL && wdcnt_q != WD_MAX) begin
      wdcnt_q <= wdcnt_d;
      if (wdcnt_d == WD_MAX) begin
        rx_timeout_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_clk_ctrl.sv
// tb/tb_i2s_clk_ctrl.sv - randomized scoreboard bench for i2s_clk_ctrl
module tb_i2s_clk_ctrl;

  localparam int SLOT = 16;
  localparam int TO   = 100;

  logic        mclk = 1'b1;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        rx_data_valid = 1'b0;
  logic [7:0]  div = 8'd0;
  logic        bclk;
  logic        wclk;
  logic        running;
  logic [15:0] frame_count;
  logic        rx_timeout;

  i2s_clk_ctrl #(
    .SLOT_BITS(SLOT),
    .DIV_W(8),
    .TIMEOUT(TO)
  ) dut (
    .mclk(mclk),
    .reset(reset),
    .enable(enable),
    .div(div),
    .rx_data_valid(rx_data_valid),
    .bclk(bclk),
    .wclk(wclk),
    .running(running),
    .frame_count(frame_count),
    .rx_timeout(rx_timeout)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    int          cyc;
    logic [19:0] v;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  // Reference model: mode 0=idle 1=run 2=drain 3=tail; timing from phase arithmetic.
  int          m_mode = 0;
  int          m_t0 = 0;
  int          m_pb = 0;
  int          m_dl = 0;
  int          m_fc = 0;
  int          m_wd = 0;
  bit          m_to = 0;
  int          m_n = 0;
  logic [19:0] m_prev = '0;
  int          rv_mode = 0;

  task automatic step(input bit en, input bit rst);
    bit   rv;
    int   d;
    int   nn;
    int   h;
    int   p;
    bit   b;
    bit   w;
    bit   r;
    logic [19:0] v;
    @(negedge mclk);
    case (rv_mode)
      1:       rv = ((m_n % 64) == 63);
      2:       rv = ($urandom_range(0, 39) == 0);
      default: rv = 1'b0;
    endcase
    d = $urandom_range(0, 3);
    reset = rst;
    enable = en;
    rx_data_valid = rv;
    div = 8'(d);
    nn = m_n + 1;
    h = m_dl + 1;
    if (rst) begin
      m_mode = 0;
      m_fc = 0;
      m_to = 0;
      m_wd = 0;
    end else begin
      if (m_mode == 0) m_wd = 0;
      else if (rv) m_wd = 0;
      else if (m_mode == 1 || m_mode == 2) begin
        if (m_wd < TO) m_wd++;
        if (m_wd == TO) m_to = 1;
      end
      case (m_mode)
        0: if (en) begin
          m_mode = 1;
          m_t0 = nn;
          m_dl = d;
          m_to = 0;
          m_wd = 0;
        end
        1, 2: begin
          if (((nn - m_t0) % (4 * SLOT * h)) == 0) begin
            m_fc = (m_fc + 1) % 65536;
            if (m_mode == 2) begin
              m_mode = 3;
              m_pb = nn;
            end
          end
          if (m_mode == 1 && !en) m_mode = 2;
        end
        default: if ((nn - m_pb) == 2 * h) m_mode = 0;
      endcase
    end
    h = m_dl + 1;
    case (m_mode)
      1, 2: begin
        p = nn - m_t0;
        b = ((p % (2 * h)) >= h);
        w = (((p / (2 * SLOT * h)) % 2) == 1);
        r = 1;
      end
      3: begin
        b = ((nn - m_pb) >= h);
        w = 0;
        r = 1;
      end
      default: begin
        b = 0;
        w = 0;
        r = 0;
      end
    endcase
    v = {b, w, r, m_to, 16'(m_fc)};
    if (v != m_prev) exp_q.push_back('{cyc: nn, v: v});
    m_prev = v;
    m_n = nn;
  endtask

  // Monitor: every output change must match the next expected event exactly.
  initial begin
    logic [19:0] prev;
    logic [19:0] cur;
    int          mc;
    ev_t         e;
    prev = '0;
    mc = 0;
    forever begin
      @(posedge mclk);
      #1;
      mc++;
      cur = {bclk, wclk, running, rx_timeout, frame_count};
      if (cur !== prev) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_change cyc=%0d got=%h required=no change", mc, cur);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != mc || e.v !== cur) begin
            bad++;
            $display("FAIL event cyc=%0d got=%h required cyc=%0d val=%h", mc, cur, e.cyc, e.v);
          end
        end
      end
      prev = cur;
    end
  end

  initial begin
    int run_len;
    int g;
    repeat (3) step(0, 1);
    @(posedge mclk);
    #1;
    total++;
    if ({bclk, wclk, running, rx_timeout, frame_count} !== 20'h0) begin
      bad++;
      $display("FAIL reset_state got=%h required=%h", {bclk, wclk, running, rx_timeout, frame_count}, 20'h0);
    end
    for (int s = 0; s < 24; s++) begin
      rv_mode = s % 3;
      run_len = $urandom_range(40, 1200);
      for (int k = 0; k < run_len; k++) step(1, 0);
      if (s == 7 || s == 16) begin
        step(1, 1);
      end else begin
        run_len = $urandom_range(1, 60);
        for (int k = 0; k < run_len; k++) step(0, 0);
        if ($urandom_range(0, 1) == 1) begin
          run_len = $urandom_range(1, 400);
          for (int k = 0; k < run_len; k++) step(1, 0);
        end
      end
      g = 0;
      while (m_mode != 0 && g < 5000) begin
        step(0, 0);
        g++;
      end
      run_len = $urandom_range(0, 5);
      for (int k = 0; k < run_len; k++) step(0, 0);
    end
    repeat (3) step(0, 0);
    @(posedge mclk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_events got=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2s_clk_ctrl.md
Name: i2s_clk_ctrl

Overview:
- I2S master clock sequencer for the audio receive path.
- Derives bclk and wclk from mclk with a programmable divider and starts and stops the bus cleanly on frame boundaries.
- Counts completed frames and runs a watchdog on the receiver's rx_data_valid strobe.
- Drives the bclk/wclk inputs of the I2S receiver. All logic is in the mclk domain.

Parameters:
SLOT_BITS, 16, bclk periods per channel slot (frame = 2*SLOT_BITS periods); >=2
DIV_W, 8, width of the divider input
TIMEOUT, 4096, mclk cycles without rx_data_valid while RUN before rx_timeout sets

Ports:
mclk  input  1  system/master clock
reset  input  1  synchronous, active-high
enable  input  1  level; high requests bus running, low requests stop at next frame end
div  input  DIV_W  bclk half-period = div+1 mclk cycles; sampled only on IDLE->RUN
rx_data_valid  input  1  one-cycle strobe from the I2S receiver
bclk  output  1  bit clock (registered)
wclk  output  1  word clock, 0 = first slot, 1 = second slot (registered)
running  output  1  high in RUN, DRAIN, TAIL
frame_count  output  16  completed frames, wraps 0xFFFF->0
rx_timeout  output  1  sticky watchdog flag

Behaviour:
- Reset: clock and reset are as already decided (reset reset, synchronous, active-high; clock mclk). Reset values: state=IDLE, bclk=0, wclk=0, running=0, frame_count=0, rx_timeout=0, all counters 0. Reset mid-operation aborts immediately to these values with no tail.
- States: IDLE, RUN, DRAIN, TAIL.
- Half-period counter hcnt:
  - Runs 0..div_l, where div_l is div latched on IDLE->RUN.
  - At hcnt==div_l: bclk toggles and hcnt returns to 0.
  - A div change while running is ignored.
- Bit timing:
  - Each bclk period is low for div_l+1 cycles, then high for div_l+1 cycles.
  - A period ends on the bclk 1->0 transition.
  - bitcnt counts completed periods 0..SLOT_BITS-1.
- Slot boundary: on the falling bclk edge where bitcnt==SLOT_BITS-1:
  - wclk toggles in the same mclk cycle;
  - bitcnt returns to 0.
- Frame completion: a wclk 1->0 transition increments frame_count in that same cycle (RUN or DRAIN).
- IDLE: bclk=0, wclk=0, counters held at 0. If enable=1, go to RUN next cycle with hcnt=0, bclk=0, wclk=0.
- RUN:
  - Free-running as above.
  - If enable=0, go to DRAIN; the transition does not disturb timing.
- DRAIN:
  - Continues identically until the frame-completion edge (wclk 1->0).
  - Then goes to TAIL with hcnt=0.
  - enable reasserting during DRAIN does not cancel the stop.
- TAIL:
  - Emits exactly one extra bclk period (low div_l+1, high div_l+1) with wclk=0, so the receiver sees a rising bclk after the last wclk edge.
  - Then goes to IDLE on what would be the falling edge; bclk=0.
  - If enable=1 in IDLE, RUN restarts the following cycle.
- Bus levels: wclk is 0 in IDLE and TAIL, so no spurious wclk edges occur on stop or start. In IDLE, bclk and wclk have no glitches and are constant.
- Watchdog (wdcnt, width ceil(log2(TIMEOUT+1))):
  - Clears on rx_data_valid, in IDLE, and on IDLE->RUN.
  - Otherwise increments in RUN/DRAIN, saturating at TIMEOUT.
  - rx_timeout sets when wdcnt reaches TIMEOUT.
  - rx_timeout stays set until reset or the next IDLE->RUN.
  - rx_data_valid in the same cycle as the wdcnt==TIMEOUT-1 increment clears the counter; no flag is set.

Test Plan:
- div=0, SLOT_BITS=16, enable held 1 -> bclk period 2 mclk; wclk toggles every 32 mclk on a bclk falling edge; frame_count increments every 64 mclk.
- div=3 -> bclk low 4 / high 4 cycles. Change div to 0 mid-RUN -> timing unchanged until stop and restart, then period 2.
- Drop enable mid-second-slot -> frame finishes and frame_count increments once. Then one TAIL period (8 mclk at div=3) with wclk=0. Then IDLE with bclk=0, running=0.
- Re-raise enable during DRAIN -> stop completes, one IDLE cycle occurs, RUN restarts with bclk=0, wclk=0; frame_count continues without reset.
- TIMEOUT=100 with no rx_data_valid -> rx_timeout=1 at cycle 100 after RUN entry. Pulse rx_data_valid every 64 cycles instead -> rx_timeout stays 0. After stop and restart the flag clears.
- Assert reset mid-slot -> next cycle all outputs equal reset values. Preload frame_count=0xFFFF by running 65535 frames (div=0) -> next completed frame gives 0x0000.
